// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// flush, and a saturating stall counter. All state updates on the falling clock edge.
module ex_mem_stage #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int RESULT_SRC_W = 2,
  parameter bit SKID_EN      = 1'b1,
  parameter int PERF_W       = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [XLEN-1:0]         i_alu_result_ex,
  input  logic [XLEN-1:0]         i_rs2_data_ex,
  input  logic [XLEN-1:0]         i_pc_p_4_ex,
  input  logic [REG_ADDR_W-1:0]   i_rd_ex,
  input  logic                    i_register_write_ex,
  input  logic                    i_mem_write_enable_ex,
  input  logic [RESULT_SRC_W-1:0] i_result_src_ex,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [XLEN-1:0]         o_alu_result_mem,
  output logic [XLEN-1:0]         o_rs2_data_mem,
  output logic [XLEN-1:0]         o_pc_p_4_mem,
  output logic [REG_ADDR_W-1:0]   o_rd_mem,
  output logic [RESULT_SRC_W-1:0] o_result_src_mem,
  output logic                    o_register_write_mem,
  output logic                    o_mem_write_enable_mem,
  output logic                    o_fwd_write_mem,
  output logic [PERF_W-1:0]       o_stall_cycles
);

  // S_EMPTY: no entry valid | S_ONE: main valid | S_TWO: main and skid valid
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  localparam int PW = 3*XLEN + REG_ADDR_W + RESULT_SRC_W + 2;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_main_valid;
  logic              r_skid_valid;
  logic [PW-1:0]     r_main;
  logic [PW-1:0]     r_skid;
  logic [PERF_W-1:0] r_stall;
  logic [PW-1:0]     w_in_payload;
  logic              w_accept;
  logic              w_retire;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic              w_rw;
  logic              w_mw;

  assign w_in_payload = {i_alu_result_ex, i_rs2_data_ex, i_pc_p_4_ex, i_rd_ex,
                         i_result_src_ex, i_register_write_ex, i_mem_write_enable_ex};

  assign o_out_valid = r_main_valid;
  assign o_in_ready  = SKID_EN ? !r_skid_valid : (!r_main_valid || i_out_ready);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_retire    = r_main_valid && i_out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = S_ONE;
          w_load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_retire) begin
          w_load_main_in = 1'b1;
        end else if (w_accept && SKID_EN) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_retire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_retire) begin
          w_state_nxt      = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush drops everything, including a beat accepted on this edge; data regs hold.
    if (i_flush) begin
      w_state_nxt      = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
      r_stall      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_main_valid <= (w_state_nxt != S_EMPTY);
      r_skid_valid <= (w_state_nxt == S_TWO);
      if (w_load_main_in) begin
        r_main <= w_in_payload;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_payload;
      end
      if (r_main_valid && !i_out_ready && (r_stall != {PERF_W{1'b1}})) begin
        r_stall <= r_stall + {{(PERF_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign {o_alu_result_mem, o_rs2_data_mem, o_pc_p_4_mem, o_rd_mem,
          o_result_src_mem, w_rw, w_mw} = r_main;

  assign o_register_write_mem   = w_rw && r_main_valid;
  assign o_mem_write_enable_mem = w_mw && r_main_valid;
  assign o_fwd_write_mem        = w_rw && r_main_valid && (o_rd_mem != '0);
  assign o_stall_cycles         = r_stall;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table driven through a queue-based scoreboard,
// plus hand sequences for async reset and the SKID_EN=0 / PERF_W=4 variant.
module tb_ex_mem_stage;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        exp_rdy;
    logic        exp_ov;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [1:0]  rsrc;
    logic        rw;
    logic        mw;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fl = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic fl2 = 1'b0, iv2 = 1'b0, ordy2 = 1'b0;
  logic [31:0] alu_ex = '0, rs2_ex = '0, pc_ex = '0;
  logic [4:0]  rd_ex = '0;
  logic [1:0]  rsrc_ex = '0;
  logic        rw_ex = 1'b0, mw_ex = 1'b0;

  logic        in_rdy, ov, rw_m, mw_m, fwd_m;
  logic [31:0] alu_m, rs2_m, pc_m;
  logic [4:0]  rd_m;
  logic [1:0]  rsrc_m;
  logic [15:0] stall;

  logic        in_rdy2, ov2, rw_m2, mw_m2, fwd_m2;
  logic [31:0] alu_m2, rs2_m2, pc_m2;
  logic [4:0]  rd_m2;
  logic [1:0]  rsrc_m2;
  logic [3:0]  stall2;

  int n_tests = 0;
  int n_fail  = 0;
  beat_t q[$];
  int m_stall = 0;
  vec_t vecs[19];

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32), .REG_ADDR_W(5), .RESULT_SRC_W(2), .SKID_EN(1'b1), .PERF_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(fl), .i_in_valid(iv), .o_in_ready(in_rdy),
    .i_alu_result_ex(alu_ex), .i_rs2_data_ex(rs2_ex), .i_pc_p_4_ex(pc_ex), .i_rd_ex(rd_ex),
    .i_register_write_ex(rw_ex), .i_mem_write_enable_ex(mw_ex), .i_result_src_ex(rsrc_ex),
    .o_out_valid(ov), .i_out_ready(ordy), .o_alu_result_mem(alu_m), .o_rs2_data_mem(rs2_m),
    .o_pc_p_4_mem(pc_m), .o_rd_mem(rd_m), .o_result_src_mem(rsrc_m),
    .o_register_write_mem(rw_m), .o_mem_write_enable_mem(mw_m), .o_fwd_write_mem(fwd_m),
    .o_stall_cycles(stall)
  );

  ex_mem_stage #(.XLEN(32), .REG_ADDR_W(5), .RESULT_SRC_W(2), .SKID_EN(1'b0), .PERF_W(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_flush(fl2), .i_in_valid(iv2), .o_in_ready(in_rdy2),
    .i_alu_result_ex(alu_ex), .i_rs2_data_ex(rs2_ex), .i_pc_p_4_ex(pc_ex), .i_rd_ex(rd_ex),
    .i_register_write_ex(rw_ex), .i_mem_write_enable_ex(mw_ex), .i_result_src_ex(rsrc_ex),
    .o_out_valid(ov2), .i_out_ready(ordy2), .o_alu_result_mem(alu_m2), .o_rs2_data_mem(rs2_m2),
    .o_pc_p_4_mem(pc_m2), .o_rd_mem(rd_m2), .o_result_src_mem(rsrc_m2),
    .o_register_write_mem(rw_m2), .o_mem_write_enable_mem(mw_m2), .o_fwd_write_mem(fwd_m2),
    .o_stall_cycles(stall2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t make_beat(input logic [31:0] alu, input logic [4:0] rd,
                                      input logic rw, input logic mw);
    beat_t b;
    b.alu  = alu;
    b.rs2  = alu ^ 32'hFFFF_0000;
    b.pc   = alu + 32'd4;
    b.rd   = rd;
    b.rsrc = alu[5:4];
    b.rw   = rw;
    b.mw   = mw;
    return b;
  endfunction

  task automatic apply_payload(input beat_t b);
    alu_ex  = b.alu;
    rs2_ex  = b.rs2;
    pc_ex   = b.pc;
    rd_ex   = b.rd;
    rsrc_ex = b.rsrc;
    rw_ex   = b.rw;
    mw_ex   = b.mw;
  endtask

  task automatic check_head(input string tag);
    beat_t h;
    h = q[0];
    chk({tag, "_alu"}, alu_m, h.alu);
    chk({tag, "_rs2"}, rs2_m, h.rs2);
    chk({tag, "_pc"}, pc_m, h.pc);
    chk({tag, "_rd"}, {27'd0, rd_m}, {27'd0, h.rd});
    chk({tag, "_rsrc"}, {30'd0, rsrc_m}, {30'd0, h.rsrc});
    chk({tag, "_rw"}, {31'd0, rw_m}, {31'd0, h.rw});
    chk({tag, "_mw"}, {31'd0, mw_m}, {31'd0, h.mw});
    chk({tag, "_fwd"}, {31'd0, fwd_m}, {31'd0, (h.rw && (h.rd != 5'd0))});
  endtask

  task automatic drive_cycle(input vec_t v);
    beat_t b;
    logic  m_rdy, acc, ret;
    @(posedge clk); #1;
    chk("out_valid_model", {31'd0, ov}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) check_head("hold");
    else chk("gated_ctrl", {29'd0, rw_m, mw_m, fwd_m}, 32'd0);
    chk("stall_cycles", {16'd0, stall}, m_stall);
    b    = make_beat(v.alu, v.rd, v.rw, v.mw);
    apply_payload(b);
    iv   = v.iv;
    ordy = v.ordy;
    fl   = v.fl;
    #1;
    m_rdy = (q.size() < 2);
    chk("in_ready_model", {31'd0, in_rdy}, {31'd0, m_rdy});
    chk("in_ready_vec", {31'd0, in_rdy}, {31'd0, v.exp_rdy});
    acc = v.iv && m_rdy;
    ret = (q.size() > 0) && v.ordy;
    if (ret) check_head("retire");
    @(negedge clk);
    if ((q.size() > 0) && !v.ordy && (m_stall < 65535)) m_stall++;
    if (v.fl) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; iv = 1'b0; iv2 = 1'b0; ordy = 1'b0; ordy2 = 1'b0; fl = 1'b0; fl2 = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, ov}, 32'd0);
    chk("rst_in_ready", {31'd0, in_rdy}, 32'd1);
    chk("rst_alu", alu_m, 32'd0);
    chk("rst_ctrl", {29'd0, rw_m, mw_m, fwd_m}, 32'd0);
    chk("rst_stall", {16'd0, stall}, 32'd0);
    chk("rst_in_ready2", {31'd0, in_rdy2}, 32'd1);
    chk("rst_out_valid2", {31'd0, ov2}, 32'd0);
    chk("rst_stall2", {28'd0, stall2}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_stall = 0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_rdy}, 32'd1);
    chk("post_rst_in_ready2", {31'd0, in_rdy2}, 32'd1);
  endtask

  initial begin
    vec_t  v;
    beat_t b;
    //          iv    ordy  fl    alu         rd     rw    mw    rdy   ov
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h10, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h20, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h30, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h40, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h11, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h22, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h33, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h33, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h44, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h55, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h66, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h77, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h88, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0};

    do_reset();

    for (int i = 0; i < 19; i++) begin
      drive_cycle(vecs[i]);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, ov}, {31'd0, vecs[i].exp_ov});
      if (i == 8) chk("skid_stall_3", {16'd0, stall}, 32'd3);
    end

    // Hold a write beat, then assert reset between edges.
    v = '{1'b1, 1'b0, 1'b0, 32'h99, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1};
    drive_cycle(v);
    @(posedge clk); #1;
    iv = 1'b0;
    #1;
    chk("pre_arst_rw", {31'd0, rw_m}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, ov}, 32'd0);
    chk("arst_ctrl", {29'd0, rw_m, mw_m, fwd_m}, 32'd0);
    chk("arst_alu", alu_m, 32'd0);
    chk("arst_rd", {27'd0, rd_m}, 32'd0);
    chk("arst_stall", {16'd0, stall}, 32'd0);
    chk("arst_in_ready", {31'd0, in_rdy}, 32'd1);
    do_reset();

    // SKID_EN=0, PERF_W=4 instance.
    @(posedge clk); #1;
    b = make_beat(32'hAB, 5'd2, 1'b1, 1'b0);
    apply_payload(b);
    iv2 = 1'b1; ordy2 = 1'b1;
    #1;
    chk("ns_in_ready_empty", {31'd0, in_rdy2}, 32'd1);
    @(negedge clk); #1;
    chk("ns_out_valid", {31'd0, ov2}, 32'd1);
    chk("ns_alu", alu_m2, 32'hAB);
    chk("ns_fwd", {31'd0, fwd_m2}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      b = make_beat(32'hCD + i, 5'd4, 1'b1, 1'b0);
      apply_payload(b);
      ordy2 = 1'b1;
      #1;
      chk("ns_in_ready_follow_hi", {31'd0, in_rdy2}, 32'd1);
      ordy2 = 1'b0;
      #1;
      chk("ns_in_ready_follow_lo", {31'd0, in_rdy2}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("ns_stall_sat", {28'd0, stall2}, 32'd15);
    chk("ns_alu_held", alu_m2, 32'hAB);
    chk("ns_out_valid_held", {31'd0, ov2}, 32'd1);
    iv2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
